// File: rtl/mac_iter.sv
// mac_iter: iterative multiply / multiply-accumulate unit with MACH/MACL accumulator pair.
//
// The multiplier is consumed STEP bits per clock-enabled cycle, so a multiply
// takes N = W/STEP compute cycles plus one finish cycle. The operation's
// results are committed to MACH/MACL in the same cycle as the registered
// DONE pulse.
//
// Optional feature (compile-time macro MAC_ITER_EARLY_EXIT_EN):
//   defined   - CALC stops as soon as the unconsumed multiplier bits are all zero
//   undefined - CALC always runs N cycles (fixed latency N+1)
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   CE            clock enable; all state holds while low
//   CMD_VALID     command request; accepted when CE && CMD_VALID && CMD_READY
//   CMD_READY     unit idle
//   CMD_OP        0 MULL, 1 DMULU, 2 DMULS, 3 MACS, 4 MACW, 5 CLRMAC, 6/7 reserved
//   CMD_A, CMD_B  multiplicand, multiplier
//   CMD_SAT       saturation enable for MACS/MACW
//   ACC_WR        direct accumulator write (only taken while idle)
//   ACC_SEL       bit0 -> MACL, bit1 -> MACH
//   ACC_DI        accumulator write data
//   MACH, MACL    accumulator halves
//   BUSY          operation in flight (CALC or FIN)
//   DONE          one CE-cycle pulse, results valid
module mac_iter #(
  parameter int W     = 32,
  parameter int STEP  = 8,
  parameter int SAT_L = 48
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic [2:0]   CMD_OP,
  input  logic [W-1:0] CMD_A,
  input  logic [W-1:0] CMD_B,
  input  logic         CMD_SAT,
  input  logic         ACC_WR,
  input  logic [1:0]   ACC_SEL,
  input  logic [W-1:0] ACC_DI,
  output logic [W-1:0] MACH,
  output logic [W-1:0] MACL,
  output logic         BUSY,
  output logic         DONE
);

  localparam int N  = W / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  localparam logic [2:0] OP_MULL   = 3'd0;
  localparam logic [2:0] OP_DMULU  = 3'd1;
  localparam logic [2:0] OP_DMULS  = 3'd2;
  localparam logic [2:0] OP_MACS   = 3'd3;
  localparam logic [2:0] OP_MACW   = 3'd4;
  localparam logic [2:0] OP_CLRMAC = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sat_q, sat_d;
  logic            neg_q, neg_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  a_sh_q, a_sh_d;
  logic [2*W-1:0]  p_q, p_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    mach_q, mach_d;
  logic [W-1:0]    macl_q, macl_d;

  logic                  accept;
  logic                  signed_op;
  logic                  calc_last;
  logic [W-1:0]          a_abs, b_abs;
  logic signed [2*W-1:0] prod_s;
  logic signed [2*W-1:0] acc_s;
  logic signed [2*W:0]   sum_s;
  logic signed [2*W:0]   sum_w;

  // Magnitude of a two's complement value when en is set; the most negative
  // value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic en);
    return (en && x[W-1]) ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Clamp a 2W+1-bit signed sum into SAT_L signed bits, sign-extended to 2W.
  function automatic logic [2*W-1:0] sat_macs(input logic signed [2*W:0] s,
                                               input logic en);
    logic signed [2*W:0] hi;
    logic signed [2*W:0] lo;
    logic signed [2*W:0] r;
    hi = '0;
    hi[SAT_L-2:0] = '1;
    lo = '1;
    lo[SAT_L-2:0] = '0;
    r = s;
    if (en && (s > hi)) r = hi;
    else if (en && (s < lo)) r = lo;
    return r[2*W-1:0];
  endfunction

  // Word saturation: keep MACH if the sum fits W signed bits, otherwise clamp
  // MACL and flag the overflow by setting MACH to 1.
  function automatic logic [2*W-1:0] sat_macw(input logic signed [2*W:0] s,
                                               input logic [W-1:0] mach);
    logic [W+1:0] top;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    top = s[2*W:W-1];
    hi  = {1'b0, {(W-1){1'b1}}};
    lo  = {1'b1, {(W-1){1'b0}}};
    if ((top == '0) || (top == '1)) return {mach, s[W-1:0]};
    return {{(W-1){1'b0}}, 1'b1, (s[2*W] ? lo : hi)};
  endfunction

  assign signed_op = (CMD_OP == OP_DMULS) || (CMD_OP == OP_MACS) || (CMD_OP == OP_MACW);
  assign a_abs     = mag(CMD_A, signed_op);
  assign b_abs     = mag(CMD_B, signed_op);
  assign accept    = CMD_VALID && (state_q == S_IDLE);

  assign prod_s = neg_q ? (~p_q + {{(2*W-1){1'b0}}, 1'b1}) : p_q;
  assign acc_s  = {mach_q, macl_q};
  assign sum_s  = {acc_s[2*W-1], acc_s} + {prod_s[2*W-1], prod_s};
  assign sum_w  = {{(W+1){macl_q[W-1]}}, macl_q} + {prod_s[2*W-1], prod_s};

`ifdef MAC_ITER_EARLY_EXIT_EN
  assign calc_last = (cnt_q == '0) || ((b_q >> STEP) == '0);
`else
  assign calc_last = (cnt_q == '0);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (CMD_OP <= OP_MACW) ? S_CALC : S_FIN;
      S_CALC:  if (calc_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and accumulator next values
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    sat_d  = sat_q;
    neg_d  = neg_q;
    a_sh_d = a_sh_q;
    b_d    = b_q;
    p_d    = p_q;
    mach_d = mach_q;
    macl_d = macl_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A direct write lands before any accepted command reads the accumulator.
        if (ACC_WR) begin
          if (ACC_SEL[0]) macl_d = ACC_DI;
          if (ACC_SEL[1]) mach_d = ACC_DI;
        end
        if (accept) begin
          op_d   = CMD_OP;
          sat_d  = CMD_SAT;
          neg_d  = signed_op && (CMD_A[W-1] ^ CMD_B[W-1]);
          a_sh_d = {{W{1'b0}}, a_abs};
          b_d    = b_abs;
          p_d    = '0;
          cnt_d  = CNT_INIT;
        end
      end
      S_CALC: begin
        // Multiplicand is pre-shifted so each STEP-bit digit lands at its weight.
        p_d    = p_q + a_sh_q * {{(2*W-STEP){1'b0}}, b_q[STEP-1:0]};
        a_sh_d = a_sh_q << STEP;
        b_d    = b_q >> STEP;
        if (!calc_last) cnt_d = cnt_q - 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
        case (op_q)
          OP_MULL:   macl_d = prod_s[W-1:0];
          OP_DMULU:  {mach_d, macl_d} = p_q;
          OP_DMULS:  {mach_d, macl_d} = prod_s;
          OP_MACS:   {mach_d, macl_d} = sat_macs(sum_s, sat_q);
          OP_MACW:   {mach_d, macl_d} = sat_q ? sat_macw(sum_w, mach_q) : sum_s[2*W-1:0];
          OP_CLRMAC: {mach_d, macl_d} = '0;
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sat_q   <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      a_sh_q  <= '0;
      b_q     <= '0;
      p_q     <= '0;
      mach_q  <= '0;
      macl_q  <= '0;
    end else if (CE) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sat_q   <= sat_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      p_q     <= p_d;
      mach_q  <= mach_d;
      macl_q  <= macl_d;
    end
  end

  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign MACH      = mach_q;
  assign MACL      = macl_q;

endmodule

// File: tb/tb_mac_iter.sv
module tb_mac_iter;

  localparam int W     = 32;
  localparam int STEP  = 8;
  localparam int SAT_L = 48;
  localparam int N     = W / STEP;
`ifdef MAC_ITER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         CE = 1'b0;
  logic         CMD_VALID = 1'b0;
  logic         CMD_READY;
  logic [2:0]   CMD_OP = '0;
  logic [W-1:0] CMD_A = '0;
  logic [W-1:0] CMD_B = '0;
  logic         CMD_SAT = 1'b0;
  logic         ACC_WR = 1'b0;
  logic [1:0]   ACC_SEL = '0;
  logic [W-1:0] ACC_DI = '0;
  logic [W-1:0] MACH;
  logic [W-1:0] MACL;
  logic         BUSY;
  logic         DONE;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_mach = '0;
  logic [31:0] m_macl = '0;

  mac_iter #(.W(W), .STEP(STEP), .SAT_L(SAT_L)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_SAT(CMD_SAT),
    .ACC_WR(ACC_WR), .ACC_SEL(ACC_SEL), .ACC_DI(ACC_DI),
    .MACH(MACH), .MACL(MACL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int bitlen(input logic [31:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (x[i]) n = i + 1;
    return n;
  endfunction

  // Architectural result of one command, from plain wide arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic sat,
                                        input logic [31:0] mh, input logic [31:0] ml);
    logic signed [127:0] pu, ps, acc, s, smax, smin, wmax, wmin;
    logic [63:0] r;
    pu   = {96'b0, a} * {96'b0, b};
    ps   = $signed({{96{a[31]}}, a}) * $signed({{96{b[31]}}, b});
    acc  = {{64{mh[31]}}, mh, ml};
    smax = (128'sd1 <<< (SAT_L - 1)) - 128'sd1;
    smin = -(128'sd1 <<< (SAT_L - 1));
    wmax = (128'sd1 <<< 31) - 128'sd1;
    wmin = -(128'sd1 <<< 31);
    r = {mh, ml};
    case (op)
      3'd0: r[31:0] = pu[31:0];
      3'd1: r = pu[63:0];
      3'd2: r = ps[63:0];
      3'd3: begin
        s = acc + ps;
        if (sat && s > smax) s = smax;
        else if (sat && s < smin) s = smin;
        r = s[63:0];
      end
      3'd4: begin
        if (!sat) begin
          s = acc + ps;
          r = s[63:0];
        end else begin
          s = $signed({{96{ml[31]}}, ml}) + ps;
          if (s > wmax) r = {32'd1, 32'h7FFF_FFFF};
          else if (s < wmin) r = {32'd1, 32'h8000_0000};
          else r[31:0] = s[31:0];
        end
      end
      3'd5: r = '0;
      default: ;
    endcase
    return r;
  endfunction

  // CE-enabled cycles from accept edge to the DONE edge.
  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] mb;
    int cyc;
    mb  = (op >= 3'd2 && b[31]) ? (32'd0 - b) : b;
    cyc = (bitlen(mb) + STEP - 1) / STEP;
    if (cyc < 1) cyc = 1;
    if (!EARLY) cyc = N;
    return (op > 3'd4) ? 1 : cyc + 1;
  endfunction

  task automatic acc_write(input logic [1:0] sel, input logic [31:0] di);
    CE = 1'b1; ACC_WR = 1'b1; ACC_SEL = sel; ACC_DI = di;
    step();
    ACC_WR = 1'b0;
    if (sel[0]) m_macl = di;
    if (sel[1]) m_mach = di;
    check("accwr_mach", MACH, m_mach);
    check("accwr_macl", MACL, m_macl);
  endtask

  // Issue one command and follow it to DONE. noisy toggles CE and throws
  // ignored ACC_WR pulses at the unit while it is busy.
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sat, input bit noisy, input bit wr,
                         input logic [1:0] sel, input logic [31:0] di);
    logic [63:0] exp;
    int exp_lat, ce_cnt;
    bit seen, busy_ok;
    CE = 1'b1;
    check("ready_before_cmd", CMD_READY, 1'b1);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_A = a; CMD_B = b; CMD_SAT = sat;
    ACC_WR = wr; ACC_SEL = sel; ACC_DI = di;
    step();
    CMD_VALID = 1'b0; ACC_WR = 1'b0;
    if (wr && sel[0]) m_macl = di;
    if (wr && sel[1]) m_mach = di;
    exp = model(op, a, b, sat, m_mach, m_macl);
    exp_lat = exp_latency(op, b);
    ce_cnt = 0; seen = 0; busy_ok = 1;
    for (int i = 0; i < 200; i++) begin
      if (!BUSY || CMD_READY || DONE) busy_ok = 0;
      if (noisy) begin
        CE = 1'($urandom_range(0, 1));
        ACC_WR = 1'($urandom_range(0, 1));
        ACC_SEL = 2'($urandom_range(0, 3));
        ACC_DI = $urandom;
      end
      step();
      if (CE) ce_cnt++;
      ACC_WR = 1'b0;
      if (DONE) begin
        seen = 1;
        break;
      end
    end
    CE = 1'b1;
    check("busy_while_running", busy_ok, 1'b1);
    check("done_seen", seen, 1'b1);
    check("latency", ce_cnt, exp_lat);
    check("result", {MACH, MACL}, exp);
    check("ready_in_done", CMD_READY, 1'b1);
    m_mach = exp[63:32];
    m_macl = exp[31:0];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h0000_0000;
      2: return 32'h0000_0001;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [2:0] op;
    logic [1:0] sel;
    // Reset state
    #1 RST = 1'b1;
    step(); step();
    check("rst_mach", MACH, 0);
    check("rst_macl", MACL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ready", CMD_READY, 1);
    RST = 1'b0;
    CE = 1'b1;
    step();

    // MULL 7*6
    run_cmd(3'd0, 32'd7, 32'd6, 1'b0, 0, 0, 2'd0, 32'd0);
    check("mull_lit", {MACH, MACL}, 64'h0000_0000_0000_002A);

    // DMULS / DMULU with -2 and 3
    run_cmd(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 0, 2'd0, 32'd0);
    check("dmuls_lit", {MACH, MACL}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_cmd(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 0, 2'd0, 32'd0);
    check("dmulu_lit", {MACH, MACL}, 64'h0000_0002_FFFF_FFFA);

    // MACS saturating and wrapping
    acc_write(2'b10, 32'h0000_7FFF);
    acc_write(2'b01, 32'hFFFF_FFF0);
    run_cmd(3'd3, 32'h10, 32'h10, 1'b1, 0, 0, 2'd0, 32'd0);
    check("macs_sat_lit", {MACH, MACL}, 64'h0000_7FFF_FFFF_FFFF);
    acc_write(2'b10, 32'h0000_7FFF);
    acc_write(2'b01, 32'hFFFF_FFF0);
    run_cmd(3'd3, 32'h10, 32'h10, 1'b0, 0, 0, 2'd0, 32'd0);
    check("macs_nosat_lit", {MACH, MACL}, 64'h0000_8000_0000_00F0);

    // MACW saturation then an in-range MACW
    acc_write(2'b01, 32'h7FFF_FFF0);
    run_cmd(3'd4, 32'd4, 32'd8, 1'b1, 0, 0, 2'd0, 32'd0);
    check("macw_sat_lit", {MACH, MACL}, 64'h0000_0001_7FFF_FFFF);
    run_cmd(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, 2'd0, 32'd0);
    check("macw_fit_lit", {MACH, MACL}, 64'h0000_0001_7FFF_FFFE);

    // Accumulator write in the same cycle as the accepting edge
    run_cmd(3'd3, 32'd5, 32'd5, 1'b0, 0, 1, 2'b11, 32'h0000_0100);

    // Back-to-back MULL with CE toggling
    run_cmd(3'd0, 32'd1234, 32'd5678, 1'b0, 1, 0, 2'd0, 32'd0);
    run_cmd(3'd0, 32'hFFFF_0003, 32'h0001_0001, 1'b0, 1, 0, 2'd0, 32'd0);

    // Reset in the middle of a DMULU
    acc_write(2'b11, 32'h5A5A_5A5A);
    CMD_VALID = 1'b1; CMD_OP = 3'd1; CMD_A = 32'hDEAD_BEEF; CMD_B = 32'h1234_5678;
    step();
    CMD_VALID = 1'b0;
    step(); step();
    check("mid_busy", BUSY, 1);
    #2 RST = 1'b1;
    #1;
    check("midrst_mach", MACH, 0);
    check("midrst_macl", MACL, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_ready", CMD_READY, 1);
    check("midrst_done", DONE, 0);
    step();
    RST = 1'b0;
    m_mach = '0; m_macl = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DONE) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    acc_write(2'b11, 32'h0F0F_0F0F);
    run_cmd(3'd5, 32'd0, 32'd0, 1'b0, 0, 0, 2'd0, 32'd0);
    run_cmd(3'd6, 32'd3, 32'd3, 1'b0, 0, 0, 2'd0, 32'd0);

    // Randomized commands against the model
    for (int k = 0; k < 80; k++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        sel = 2'($urandom_range(1, 3));
        acc_write(sel, pick());
      end
      run_cmd(op, pick(), pick(), 1'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)), pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
